// File: rtl/scan_link_pkg.sv
// rtl/scan_link_pkg.sv - shared types for the scanner-to-scanner link arbiter
package scan_link_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } link_state_e;

  typedef logic [0:0] req_idx_t;

  function automatic logic [NUM_REQ-1:0] idx_onehot(input req_idx_t idx);
    logic [NUM_REQ-1:0] one;
    one = NUM_REQ'(1);
    return one << idx;
  endfunction

  function automatic req_idx_t other_req(input req_idx_t idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/link_bit_timer.sv
// rtl/link_bit_timer.sv - two-phase bit timer: phase 0 presents data, phase 1 raises link clock
module link_bit_timer #(
  parameter int  FRAME_BITS = 8,
  localparam int CW         = $clog2(FRAME_BITS)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  input  logic stall,
  output logic phase,
  output logic last_bit
);

  logic          phase_q, phase_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;

  assign phase    = phase_q;
  assign last_bit = (bit_cnt_q == CW'(FRAME_BITS - 1));

  always_comb begin
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    if (clear) begin
      phase_d   = 1'b0;
      bit_cnt_d = '0;
    end else if (run) begin
      if (!phase_q) begin
        // a stall only ever holds the data phase; the clock phase always completes
        if (!stall) phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (!last_bit) bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end else begin
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/scan_link_arbiter.sv
// rtl/scan_link_arbiter.sv - round-robin owner of the serial scan link, one frame per grant
module scan_link_arbiter
  import scan_link_pkg::*;
#(
  parameter int FRAME_BITS = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] bit_in,
  input  logic               remote_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] shift_en,
  output logic               link_bit,
  output logic               link_clk,
  output logic               link_start,
  output logic [NUM_REQ-1:0] done,
  output logic               busy,
  output logic [1:0]         state_o
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  link_state_e        state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] shift_en_q, shift_en_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               link_start_q, link_start_d;
  logic               busy_q, busy_d;
  req_idx_t           ptr_q, ptr_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;

  logic     tmr_phase;
  logic     tmr_last;
  req_idx_t owner;
  req_idx_t pick;

  link_bit_timer #(.FRAME_BITS(FRAME_BITS)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q == START),
    .run      (state_q == SHIFT),
    .stall    (!remote_ready),
    .phase    (tmr_phase),
    .last_bit (tmr_last)
  );

  assign owner = req_idx_t'(grant_q[1]);
  assign pick  = req[ptr_q] ? ptr_q : other_req(ptr_q);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    gap_cnt_d    = gap_cnt_q;
    shift_en_d   = '0;
    done_d       = '0;
    link_start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (remote_ready && (req != '0)) begin
          state_d      = START;
          grant_d      = idx_onehot(pick);
          link_start_d = 1'b1;
        end
      end
      START: state_d = SHIFT;
      SHIFT: begin
        // shift_en lines up with the cycle in which link_clk is high
        if (!tmr_phase && remote_ready) begin
          shift_en_d = grant_q;
        end else if (tmr_phase && tmr_last) begin
          done_d    = grant_q;
          state_d   = GAP;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d   = IDLE;
          grant_d   = '0;
          gap_cnt_d = '0;
          ptr_d     = other_req(owner);
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      shift_en_q   <= '0;
      done_q       <= '0;
      link_start_q <= 1'b0;
      busy_q       <= 1'b0;
      ptr_q        <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      shift_en_q   <= shift_en_d;
      done_q       <= done_d;
      link_start_q <= link_start_d;
      busy_q       <= busy_d;
      ptr_q        <= ptr_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign grant      = grant_q;
  assign shift_en   = shift_en_q;
  assign done       = done_q;
  assign link_start = link_start_q;
  assign busy       = busy_q;
  assign state_o    = state_q;
  assign link_clk   = tmr_phase;
  assign link_bit   = (grant_q != '0) ? bit_in[owner] : 1'b0;

endmodule
